// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
// Glyphs are active-low, bit order g,f,e,d,c,b,a.
package seven_seg_pkg;

    typedef enum logic [2:0] {
        BLANK = 3'd0,
        SCAN0 = 3'd1,
        SCAN1 = 3'd2,
        SCAN2 = 3'd3,
        SCAN3 = 3'd4
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Digit position driven in a given state; BLANK maps to 0 but is masked by the caller.
    function automatic logic [1:0] scan_digit(input state_t st);
        logic [1:0] idx;
        idx = 2'd0;
        case (st)
            SCAN1:   idx = 2'd1;
            SCAN2:   idx = 2'd2;
            SCAN3:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seven_seg_scan_hex_to_seg7.sv
// Combinational hex digit to active-low seven-segment glyph decoder.
module hex_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = GLYPH[i_hex];

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with tear-free shadow loading.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LEADING_BLANK_EN.
//
// state | meaning
// BLANK | after reset, all anodes off until the first prescaler step
// SCAN0 | digit 0 (rightmost) driven
// SCAN1 | digit 1 driven
// SCAN2 | digit 2 driven
// SCAN3 | digit 3 driven; leaving it is the frame/commit boundary
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int PRESCALE_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic        load_ack,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    logic [PRESCALE_BITS-1:0] r_prescale;
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [15:0]              r_shadow_val;
    logic [3:0]               r_shadow_dp;
    logic                     r_pend;
    logic [15:0]              r_disp_val;
    logic [3:0]               r_disp_dp;

    logic        w_step;
    logic        w_commit;
    logic [15:0] w_disp_val_nxt;
    logic [3:0]  w_disp_dp_nxt;
    logic        w_ack_nxt;
    logic [1:0]  w_digit_idx;
    logic [3:0]  w_hex;
    logic [6:0]  w_glyph;
    logic        w_blank_digit;
    logic [3:0]  w_an_nxt;
    logic [6:0]  w_seg_nxt;
    logic        w_dp_nxt;

    assign w_step   = &r_prescale;
    assign w_commit = w_step && (r_state == SCAN3);

    always_comb begin
        w_state_nxt = r_state;
        if (w_step) begin
            case (r_state)
                BLANK:   w_state_nxt = SCAN0;
                SCAN0:   w_state_nxt = SCAN1;
                SCAN1:   w_state_nxt = SCAN2;
                SCAN2:   w_state_nxt = SCAN3;
                SCAN3:   w_state_nxt = SCAN0;
                default: w_state_nxt = BLANK;
            endcase
        end
    end

    // A load landing on the commit edge bypasses the shadow so it is not delayed a frame.
    always_comb begin
        w_disp_val_nxt = r_disp_val;
        w_disp_dp_nxt  = r_disp_dp;
        w_ack_nxt      = 1'b0;
        if (w_commit) begin
            if (load) begin
                w_disp_val_nxt = value;
                w_disp_dp_nxt  = dp_in;
                w_ack_nxt      = 1'b1;
            end else if (r_pend) begin
                w_disp_val_nxt = r_shadow_val;
                w_disp_dp_nxt  = r_shadow_dp;
                w_ack_nxt      = 1'b1;
            end
        end
    end

    // Outputs are decoded from next-cycle state/display so they register alongside them.
    assign w_digit_idx = scan_digit(w_state_nxt);
    assign w_hex       = w_disp_val_nxt[{w_digit_idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .i_hex (w_hex),
        .o_seg (w_glyph)
    );

`ifdef SEVEN_SEG_LEADING_BLANK_EN
    logic [3:0] w_lead_zero;
    assign w_lead_zero[3] = (w_disp_val_nxt[15:12] == 4'd0);
    assign w_lead_zero[2] = w_lead_zero[3] && (w_disp_val_nxt[11:8] == 4'd0);
    assign w_lead_zero[1] = w_lead_zero[2] && (w_disp_val_nxt[7:4] == 4'd0);
    assign w_lead_zero[0] = 1'b0;
    assign w_blank_digit  = w_lead_zero[w_digit_idx];
`else
    assign w_blank_digit  = 1'b0;
`endif

    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = SEG_BLANK;
        w_dp_nxt  = 1'b1;
        if (w_state_nxt != BLANK) begin
            w_an_nxt  = ~(4'b0001 << w_digit_idx);
            w_seg_nxt = w_blank_digit ? SEG_BLANK : w_glyph;
            w_dp_nxt  = ~w_disp_dp_nxt[w_digit_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prescale   <= '0;
            r_state      <= BLANK;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_pend       <= 1'b0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            an           <= 4'b1111;
            seg          <= SEG_BLANK;
            dp           <= 1'b1;
            load_ack     <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
            r_state    <= w_state_nxt;
            if (load) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp_in;
            end
            if (w_commit) begin
                r_pend <= 1'b0;
            end else if (load) begin
                r_pend <= 1'b1;
            end
            r_disp_val <= w_disp_val_nxt;
            r_disp_dp  <= w_disp_dp_nxt;
            an         <= w_an_nxt;
            seg        <= w_seg_nxt;
            dp         <= w_dp_nxt;
            load_ack   <= w_ack_nxt;
            frame_tick <= w_commit;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (PRESCALE_BITS = 2) against a cycle-count display model.
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        load_ack;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    seven_seg_scan #(.PRESCALE_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .load_ack   (load_ack),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_miss = 0;
    int          n_ack = 0;
    int          m_edge = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp = '0;
    logic [15:0] m_sh_val = '0;
    logic [3:0]  m_sh_dp = '0;
    logic        m_pend = 1'b0;
    logic        m_ack = 1'b0;
    logic        m_tick = 1'b0;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge, then compare all outputs 1 time unit later.
    task automatic tick();
        logic       commit;
        int         slot;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        @(posedge clk);
        if (!rst) begin
            m_edge = 0; m_val = '0; m_dp = '0; m_sh_val = '0; m_sh_dp = '0;
            m_pend = 1'b0; m_ack = 1'b0; m_tick = 1'b0;
        end else begin
            m_edge++;
            commit = (m_edge > 4) && (m_edge % 16 == 4);
            m_ack  = 1'b0;
            m_tick = commit;
            if (commit) begin
                if (load) begin
                    m_val = value; m_dp = dp_in; m_ack = 1'b1;
                end else if (m_pend) begin
                    m_val = m_sh_val; m_dp = m_sh_dp; m_ack = 1'b1;
                end
                m_pend = 1'b0;
            end else if (load) begin
                m_sh_val = value; m_sh_dp = dp_in; m_pend = 1'b1;
            end
        end
        #1;
        e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
        if (m_edge >= 4) begin
            slot  = ((m_edge / 4) - 1) % 4;
            e_an  = 4'b1111;
            e_an[slot] = 1'b0;
            e_seg = glyph(4'((m_val >> (4 * slot)) & 16'hF));
`ifdef SEVEN_SEG_LEADING_BLANK_EN
            if (slot >= 1 && (m_val >> (4 * slot)) == 16'd0) e_seg = 7'b1111111;
`endif
            e_dp  = ~m_dp[slot];
        end
        if (load_ack === 1'b1) n_ack++;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("load_ack", 32'(load_ack), 32'(m_ack));
        chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    endtask

    task automatic run_to(input int e);
        int guard;
        guard = 0;
        while (m_edge < e && guard < 2000) begin
            tick();
            guard++;
        end
        chk("run_to_reached", 32'(m_edge >= e), 32'd1);
    endtask

    task automatic pulse(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    logic [6:0] tbl_1208 [4];
    logic [6:0] tbl_0030 [4];

    initial begin
        tbl_1208[0] = 7'b0000000; tbl_1208[1] = 7'b1000000;
        tbl_1208[2] = 7'b0100100; tbl_1208[3] = 7'b1111001;
        tbl_0030[0] = 7'b1000000; tbl_0030[1] = 7'b0110000;
`ifdef SEVEN_SEG_LEADING_BLANK_EN
        tbl_0030[2] = 7'b1111111; tbl_0030[3] = 7'b1111111;
`else
        tbl_0030[2] = 7'b1000000; tbl_0030[3] = 7'b1000000;
`endif

        // Reset with a load held high: the load must be ignored.
        rst = 1'b0; load = 1'b1; value = 16'hBEEF; dp_in = 4'hF;
        repeat (3) tick();
        load = 1'b0; rst = 1'b1;
        tick(); tick();
        chk("blank_before_step", 32'(an), 32'hF);

        // Load during BLANK, first commit at the first SCAN3->SCAN0 edge.
        pulse(16'h1208, 4'b0101);
        run_to(20);
        chk("first_commit_ack", 32'(load_ack), 32'd1);
        chk("first_commit_tick", 32'(frame_tick), 32'd1);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                chk("frame_1208_seg", 32'(seg), 32'(tbl_1208[s]));
                chk("frame_1208_an", 32'(an), 32'(~(4'b0001 << s) & 4'hF));
                tick();
            end
        end

        // Tear-free: load mid-SCAN1, old digits stay until the commit edge.
        run_to(41);
        pulse(16'hFFFF, 4'b0000);
        run_to(51);
        chk("old_digit3", 32'(seg), 32'(7'b1111001));
        tick();
        chk("tear_ack", 32'(load_ack), 32'd1);
        chk("tear_tick", 32'(frame_tick), 32'd1);
        chk("tear_seg", 32'(seg), 32'(7'b0001110));

        // Last-wins: two loads in one frame give one ack and the second value.
        n_ack = 0;
        run_to(53);
        pulse(16'h0001, 4'b0000);
        run_to(57);
        pulse(16'h0002, 4'b0000);
        run_to(68);
        chk("last_wins_acks", 32'(n_ack), 32'd1);
        chk("last_wins_seg", 32'(seg), 32'(7'b0100100));

        // Load exactly on the commit edge goes straight to the display.
        run_to(83);
        pulse(16'h000A, 4'b0000);
        chk("coincident_ack", 32'(load_ack), 32'd1);
        chk("coincident_seg", 32'(seg), 32'(7'b0001000));

        // Leading-zero handling for 0x0030.
        run_to(85);
        pulse(16'h0030, 4'b0000);
        run_to(100);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                chk("frame_0030_seg", 32'(seg), 32'(tbl_0030[s]));
                tick();
            end
        end

        // A pending load is discarded by reset.
        pulse(16'h5555, 4'b1111);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        run_to(20);
        chk("reset_drop_ack", 32'(load_ack), 32'd0);
        chk("reset_drop_seg", 32'(seg), 32'(7'b1000000));

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            load  = ($urandom_range(7) == 0);
            value = 16'($urandom);
            if ($urandom_range(3) == 0) value = value & 16'h00FF;
            dp_in = 4'($urandom);
            rst   = ($urandom_range(299) != 0);
            tick();
        end
        load = 1'b0; rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
